la_trigger_sequencer: RTL

- Multi-stage trigger sequencer in the rx_clk domain of the logic analyzer.
- Generates the single-cycle rx_trigger pulse consumed by the capture state machine.
- Each stage waits for a masked pattern match on rx_data, a programmable number of times, before advancing; after the final stage an optional delay runs, then trigger fires.
- Configuration comes from APB-side registers, already synchronized, and is latched into shadow registers on arm.

---
 rtl/la_trigger_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/la_trigger_sequencer.sv
// la_trigger_sequencer: multi-stage masked-pattern trigger sequencer in the
// rx_clk domain. Each stage waits for a programmable number of masked matches
// on rx_data. After the final stage an optional delay runs, then a single-cycle
// trigger pulse is produced for the capture state machine.
// Configuration is captured into shadow registers on arm, so APB-side edits made
// while the sequencer is busy do not affect the sequence that is running.
// Optional feature: define LA_TRIG_TIMEOUT_EN to enable a forced-trigger timeout
// (cfg_timeout / timed_out). Without it, cfg_timeout is ignored and timed_out is 0.
module la_trigger_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                              rx_clk,
  input  logic                              rst_n,
  input  logic                              arm,
  input  logic                              abort,
  input  logic [DATA_WIDTH-1:0]             rx_data,
  input  logic [SW-1:0]                     cfg_last_stage,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0]  cfg_value,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0]  cfg_mask,
  input  logic [NUM_STAGES*COUNT_WIDTH-1:0] cfg_count,
  input  logic [COUNT_WIDTH-1:0]            cfg_delay,
  input  logic [COUNT_WIDTH-1:0]            cfg_timeout,
  output logic                              trigger,
  output logic                              busy,
  output logic [SW-1:0]                     cur_stage,
  output logic                              timed_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_DELAY = 2'd2
  } state_t;

  localparam logic [SW:0]   NUM_STAGES_W = (SW + 1)'(NUM_STAGES);
  localparam logic [SW-1:0] LAST_MAX     = SW'(NUM_STAGES - 1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] occ_cnt;
  logic [COUNT_WIDTH-1:0] dly_cnt;

  // Shadow copies of the configuration, frozen for the duration of a sequence
  logic [DATA_WIDTH-1:0]  sh_value [NUM_STAGES];
  logic [DATA_WIDTH-1:0]  sh_mask  [NUM_STAGES];
  logic [COUNT_WIDTH-1:0] sh_count [NUM_STAGES];
  logic [SW-1:0]          sh_last;
  logic [COUNT_WIDTH-1:0] sh_delay;

  logic                   latch_en;
  logic [SW-1:0]          last_clamped;
  logic [DATA_WIDTH-1:0]  cur_value;
  logic [DATA_WIDTH-1:0]  cur_mask;
  logic [COUNT_WIDTH-1:0] cur_count;
  logic                   stage_hit;
  logic                   stage_done;
  logic                   nat_fire;

  // abort has priority over arm, so a simultaneous pair leaves config untouched
  assign latch_en = arm & ~abort;

  // An out-of-range final-stage index is pulled back to the last real stage
  assign last_clamped = ({1'b0, cfg_last_stage} >= NUM_STAGES_W) ? LAST_MAX : cfg_last_stage;

  assign cur_value = sh_value[cur_stage];
  assign cur_mask  = sh_mask[cur_stage];
  assign cur_count = sh_count[cur_stage];

  // A zero mask compares no bits and therefore always matches
  assign stage_hit  = ((rx_data ^ cur_value) & cur_mask) == '0;
  assign stage_done = (state == ST_MATCH) && stage_hit && (occ_cnt == cur_count);

  // Natural trigger being registered this cycle (either zero-delay finish or end of delay)
  assign nat_fire = (stage_done && (cur_stage == sh_last) && (sh_delay == '0)) ||
                    ((state == ST_DELAY) && (dly_cnt == COUNT_WIDTH'(1)));

  assign busy = (state != ST_IDLE);

  // Capture the APB-side configuration into the shadow registers on arm
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        sh_value[i] <= '0;
        sh_mask[i]  <= '0;
        sh_count[i] <= '0;
      end
      sh_last  <= '0;
      sh_delay <= '0;
    end else if (latch_en) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        sh_value[i] <= cfg_value[i*DATA_WIDTH +: DATA_WIDTH];
        sh_mask[i]  <= cfg_mask[i*DATA_WIDTH +: DATA_WIDTH];
        sh_count[i] <= cfg_count[i*COUNT_WIDTH +: COUNT_WIDTH];
      end
      sh_last  <= last_clamped;
      sh_delay <= cfg_delay;
    end
  end

`ifdef LA_TRIG_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] sh_timeout;
  logic [COUNT_WIDTH-1:0] to_cnt;
  logic                   to_hit;
  logic                   force_fire;

  // to_cnt holds the number of busy cycles including the current one, so the
  // forced pulse appears timeout+1 cycles after the arm cycle
  assign to_hit     = busy && (sh_timeout != '0) && (to_cnt == sh_timeout);
  // A natural trigger in the same cycle takes precedence and leaves timed_out clear
  assign force_fire = to_hit && !nat_fire && !abort && !arm;

  // Timeout shadow register, busy-cycle counter and sticky timed_out flag
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_timeout <= '0;
      to_cnt     <= '0;
      timed_out  <= 1'b0;
    end else if (abort) begin
      to_cnt <= '0;
    end else if (arm) begin
      sh_timeout <= cfg_timeout;
      to_cnt     <= COUNT_WIDTH'(1);
      timed_out  <= 1'b0;
    end else begin
      if (busy) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (force_fire) begin
        timed_out <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout;
  assign timed_out      = 1'b0;
`endif

  // Sequencer FSM: stage matching, occurrence counting, post-match delay, trigger pulse
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      trigger   <= 1'b0;
      cur_stage <= '0;
      occ_cnt   <= '0;
      dly_cnt   <= '0;
    end else begin
      trigger <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        cur_stage <= '0;
        occ_cnt   <= '0;
        dly_cnt   <= '0;
      end else if (arm) begin
        // Full restart; rx_data is not evaluated in the arm cycle
        state     <= ST_MATCH;
        cur_stage <= '0;
        occ_cnt   <= '0;
        dly_cnt   <= '0;
`ifdef LA_TRIG_TIMEOUT_EN
      end else if (force_fire) begin
        trigger   <= 1'b1;
        state     <= ST_IDLE;
        cur_stage <= '0;
        occ_cnt   <= '0;
        dly_cnt   <= '0;
`endif
      end else begin
        case (state)
          ST_MATCH: begin
            if (stage_hit) begin
              if (occ_cnt == cur_count) begin
                occ_cnt <= '0;
                if (cur_stage == sh_last) begin
                  if (sh_delay == '0) begin
                    trigger   <= 1'b1;
                    state     <= ST_IDLE;
                    cur_stage <= '0;
                  end else begin
                    dly_cnt <= sh_delay;
                    state   <= ST_DELAY;
                  end
                end else begin
                  cur_stage <= cur_stage + 1'b1;
                end
              end else begin
                occ_cnt <= occ_cnt + 1'b1;
              end
            end
          end
          ST_DELAY: begin
            // rx_data is ignored here; only the countdown matters
            if (dly_cnt == COUNT_WIDTH'(1)) begin
              trigger   <= 1'b1;
              state     <= ST_IDLE;
              cur_stage <= '0;
              dly_cnt   <= '0;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          ST_IDLE: begin
          end
          default: begin
            state     <= ST_IDLE;
            cur_stage <= '0;
            occ_cnt   <= '0;
            dly_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
